capsense_filter: RTL and testbench

CAPSENSE_FILTER -- requirements
Module: capsense_filter

---
 rtl/capsense_pkg.sv | 22 ++
 rtl/capsense_if.sv | 15 +
 rtl/capsense_ev_fifo.sv | 57 +++++
 rtl/capsense_filter.sv | 149 ++++++++++++++
 tb/tb_capsense_filter.sv | 393 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/capsense_pkg.sv
// Shared types and helpers for the capacitive-sense button filter.
// Holds the scan FSM encoding, the event record width and a constant clog2.
package capsense_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // Event record is {button index, press flag}.
    function automatic int ev_width(input int n);
        return clog2(n) + 1;
    endfunction

endpackage

// File: rtl/capsense_if.sv
// Event port: head of the press/release FIFO and its pop strobe.
// Head is visible combinationally while ev_valid_o; ev_rd_i pops one entry per cycle.
interface capsense_if
    import capsense_pkg::*;
#(
    parameter int N = 4
);
    logic                  ev_valid_o;
    logic [clog2(N)-1:0]   ev_idx_o;
    logic                  ev_press_o;
    logic                  ev_rd_i;

    modport master (output ev_valid_o, ev_idx_o, ev_press_o, input ev_rd_i);
    modport slave  (input ev_valid_o, ev_idx_o, ev_press_o, output ev_rd_i);
endinterface

// File: rtl/capsense_ev_fifo.sv
// Small register FIFO, head read combinationally from storage; push/pop take effect at the clock edge.
// A push while full is dropped unless a pop happens in the same cycle; pop while empty is ignored.
module capsense_ev_fifo
    import capsense_pkg::*;
#(
    parameter int WIDTH = 3,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push,
    input  logic [WIDTH-1:0] data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);
    localparam int AW = clog2(DEPTH);

    logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             do_pop, do_push;

    assign empty   = (wr_q == rd_q);
    assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign head    = mem_q[rd_q[AW-1:0]];
    assign do_pop  = pop & ~empty;
    // A simultaneous pop frees the slot the push needs.
    assign do_push = push & (~full | do_pop);

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        mem_d = mem_q;
        if (do_push) begin
            mem_d[wr_q[AW-1:0]] = data;
            wr_d                = wr_q + (AW+1)'(1);
        end
        if (do_pop) begin
            rd_d = rd_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_q <= '0;
            rd_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            mem_q <= mem_d;
        end
    end

endmodule

// File: rtl/capsense_filter.sv
// Debounces N buttons with saturating integrators, one button per cycle after each sample strobe.
// Button k updates k+2 cycles after the strobe; a full event FIFO drops events and raises sticky overflow.
module capsense_filter
    import capsense_pkg::*;
#(
    parameter int N     = 4,
    parameter int MAX   = 4,
    parameter int DEPTH = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         but_oe_i,
    input  logic [N-1:0] sampled_i,
    output logic [N-1:0] pressed_o,
    output logic         overflow_o,
    input  logic         ovf_clr_i,
    output logic         busy_o,
    capsense_if.master   ev
);
    localparam int IW = clog2(N);
    localparam int CW = clog2(MAX + 1);
    localparam int EW = ev_width(N);

    state_t          state_q, state_d;
    logic [IW-1:0]   k_q, k_d;
    logic            oe_q;
    logic [N-1:0]    snap_q, snap_d, nxt_q, nxt_d;
    logic [N-1:0]    pressed_q, pressed_d;
    logic            pend_q, pend_d;
    logic            ovf_q, ovf_d;
    logic [CW-1:0]   cnt_q [N];
    logic [CW-1:0]   cnt_d [N];
    logic [CW-1:0]   cnt_cur, cnt_new;
    logic            strobe, push, pop_ok, fifo_full, fifo_empty;
    logic [EW-1:0]   push_dat, head_dat;

    assign strobe = but_oe_i & ~oe_q;
    assign pop_ok = ev.ev_rd_i & ~fifo_empty;

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        snap_d    = snap_q;
        nxt_d     = nxt_q;
        pend_d    = pend_q;
        cnt_d     = cnt_q;
        pressed_d = pressed_q;
        push      = 1'b0;
        push_dat  = '0;
        cnt_cur   = cnt_q[k_q];
        cnt_new   = cnt_cur;

        case (state_q)
            ST_IDLE: begin
                // A fresh strobe supersedes any sample parked during the last scan.
                if (strobe) begin
                    snap_d  = sampled_i;
                    pend_d  = 1'b0;
                    k_d     = '0;
                    state_d = ST_SCAN;
                end else if (pend_q) begin
                    snap_d  = nxt_q;
                    pend_d  = 1'b0;
                    k_d     = '0;
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (strobe) begin
                    nxt_d  = sampled_i;
                    pend_d = 1'b1;
                end
                if (snap_q[k_q]) begin
                    cnt_new = (cnt_cur == CW'(MAX)) ? cnt_cur : cnt_cur + CW'(1);
                end else begin
                    cnt_new = (cnt_cur == '0) ? cnt_cur : cnt_cur - CW'(1);
                end
                cnt_d[k_q] = cnt_new;
                if (cnt_new == CW'(MAX) && !pressed_q[k_q]) begin
                    pressed_d[k_q] = 1'b1;
                    push           = 1'b1;
                    push_dat       = {k_q, 1'b1};
                end else if (cnt_new == '0 && pressed_q[k_q]) begin
                    pressed_d[k_q] = 1'b0;
                    push           = 1'b1;
                    push_dat       = {k_q, 1'b0};
                end
                if (k_q == IW'(N - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    k_d = k_q + IW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A new drop in the same cycle as a clear keeps the flag set.
    always_comb begin
        ovf_d = ovf_q;
        if (ovf_clr_i) ovf_d = 1'b0;
        if (push && fifo_full && !pop_ok) ovf_d = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= ST_IDLE;
            k_q       <= '0;
            oe_q      <= 1'b1;
            snap_q    <= '0;
            nxt_q     <= '0;
            pend_q    <= 1'b0;
            pressed_q <= '0;
            ovf_q     <= 1'b0;
            for (int i = 0; i < N; i++) cnt_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            oe_q      <= but_oe_i;
            snap_q    <= snap_d;
            nxt_q     <= nxt_d;
            pend_q    <= pend_d;
            pressed_q <= pressed_d;
            ovf_q     <= ovf_d;
            cnt_q     <= cnt_d;
        end
    end

    capsense_ev_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push  (push),
        .data  (push_dat),
        .pop   (ev.ev_rd_i),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (head_dat)
    );

    assign pressed_o                    = pressed_q;
    assign overflow_o                   = ovf_q;
    assign busy_o                       = (state_q == ST_SCAN);
    assign ev.ev_valid_o                = ~fifo_empty;
    assign {ev.ev_idx_o, ev.ev_press_o} = head_dat;

endmodule

// File: tb/tb_capsense_filter.sv
// Bench for capsense_filter: directed scenarios plus a randomized run against a per-sample reference model.
module tb_capsense_filter;
    import capsense_pkg::*;

    localparam int N     = 4;
    localparam int MAX   = 4;
    localparam int DEPTH = 4;
    localparam int IW    = clog2(N);

    logic         clk = 1'b0;
    logic         rst_i = 1'b0;
    logic         but_oe = 1'b0;
    logic         ovf_clr = 1'b0;
    logic [N-1:0] sampled = '0;
    logic [N-1:0] pressed;
    logic         overflow, busy;

    capsense_if #(.N(N)) ev_if ();

    always #5 clk = ~clk;

    capsense_filter #(.N(N), .MAX(MAX), .DEPTH(DEPTH)) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .but_oe_i   (but_oe),
        .sampled_i  (sampled),
        .pressed_o  (pressed),
        .overflow_o (overflow),
        .ovf_clr_i  (ovf_clr),
        .busy_o     (busy),
        .ev         (ev_if)
    );

    int errors = 0;
    int checks = 0;

    typedef struct { int idx; bit press; } ev_t;
    ev_t          mq[$];
    int           cnt_m [N];
    logic [N-1:0] pr_m;
    bit           ovf_m;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void model_reset();
        mq.delete();
        for (int k = 0; k < N; k++) cnt_m[k] = 0;
        pr_m  = '0;
        ovf_m = 1'b0;
    endfunction

    // One whole sample: buttons in index order, with optional pop / clear in button k's cycle.
    function automatic void model_step(input logic [N-1:0] s, input int pop_k, input int clr_k);
        for (int k = 0; k < N; k++) begin
            bit emit, pr;
            emit = 1'b0;
            pr   = 1'b0;
            if (pop_k == k && mq.size() > 0) void'(mq.pop_front());
            if (clr_k == k) ovf_m = 1'b0;
            if (s[k]) cnt_m[k] = (cnt_m[k] < MAX) ? cnt_m[k] + 1 : MAX;
            else      cnt_m[k] = (cnt_m[k] > 0) ? cnt_m[k] - 1 : 0;
            if (cnt_m[k] == MAX && !pr_m[k]) begin emit = 1'b1; pr = 1'b1; end
            else if (cnt_m[k] == 0 && pr_m[k]) begin emit = 1'b1; pr = 1'b0; end
            if (emit) begin
                pr_m[k] = pr;
                if (mq.size() < DEPTH) mq.push_back('{k, pr});
                else ovf_m = 1'b1;
            end
        end
    endfunction

    task automatic send_sample(input logic [N-1:0] s, input int pop_k, input int clr_k);
        sampled = s;
        but_oe  = 1'b1;
        tick();
        but_oe  = 1'b0;
        for (int j = 0; j < N; j++) begin
            ev_if.ev_rd_i = (j == pop_k);
            ovf_clr       = (j == clr_k);
            tick();
        end
        ev_if.ev_rd_i = 1'b0;
        ovf_clr       = 1'b0;
        model_step(s, pop_k, clr_k);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL scan_len: busy=%0b after %0d scan cycles, want 0", busy, N);
        end
        for (int t = 0; t < 20 && busy; t++) tick();
    endtask

    task automatic pop_one(output logic v, output logic [IW-1:0] i, output logic p);
        v = ev_if.ev_valid_o;
        i = ev_if.ev_idx_o;
        p = ev_if.ev_press_o;
        ev_if.ev_rd_i = 1'b1;
        tick();
        ev_if.ev_rd_i = 1'b0;
    endtask

    task automatic test_reset();
        logic [N+4:0] outs;
        ev_if.ev_rd_i = 1'b0;
        rst_i = 1'b0;
        repeat (3) tick();
        outs = {pressed, ev_if.ev_valid_o, ev_if.ev_idx_o, ev_if.ev_press_o, overflow, busy};
        checks++;
        if (outs !== '0) begin errors++; $display("FAIL reset_outputs: got %b want 0", outs); end
        but_oe = 1'b1;
        rst_i  = 1'b1;
        tick(); tick();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_no_strobe: busy=%0b want 0", busy); end
        but_oe = 1'b0;
        tick();
        model_reset();
    endtask

    task automatic test_debounce();
        repeat (3) send_sample(4'b0001, -1, -1);
        checks++;
        if (pressed !== 4'b0000 || ev_if.ev_valid_o !== 1'b0) begin
            errors++; $display("FAIL debounce_3: pressed=%b valid=%b want 0000/0", pressed, ev_if.ev_valid_o);
        end
        send_sample(4'b0001, -1, -1);
        checks++;
        if (pressed !== 4'b0001 || ev_if.ev_valid_o !== 1'b1 || ev_if.ev_idx_o !== 2'd0 || ev_if.ev_press_o !== 1'b1) begin
            errors++; $display("FAIL debounce_4: pressed=%b valid=%b idx=%0d press=%b want 0001/1/0/1",
                               pressed, ev_if.ev_valid_o, ev_if.ev_idx_o, ev_if.ev_press_o);
        end
    endtask

    task automatic test_reset_midscan();
        logic [N+4:0] outs;
        logic v, p; logic [IW-1:0] i;
        send_sample(4'b0000, -1, -1);
        checks++;
        if (pressed !== 4'b0001) begin errors++; $display("FAIL hysteresis: pressed=%b want 0001", pressed); end
        sampled = 4'b0001; but_oe = 1'b1;
        tick();
        but_oe = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL midscan_busy: busy=%0b want 1", busy); end
        #2 rst_i = 1'b0;
        #1;
        outs = {pressed, ev_if.ev_valid_o, ev_if.ev_idx_o, ev_if.ev_press_o, overflow, busy};
        checks++;
        if (outs !== '0) begin errors++; $display("FAIL async_reset: got %b want 0", outs); end
        @(posedge clk); #1;
        rst_i = 1'b1;
        tick();
        model_reset();
        send_sample(4'b0001, -1, -1);
        checks++;
        if (pressed !== 4'b0000 || ev_if.ev_valid_o !== 1'b0) begin
            errors++; $display("FAIL post_reset_sample: pressed=%b valid=%b want 0000/0", pressed, ev_if.ev_valid_o);
        end
        repeat (2) send_sample(4'b0001, -1, -1);
        checks++;
        if (ev_if.ev_valid_o !== 1'b0) begin errors++; $display("FAIL post_reset_cnt3: valid=%b want 0", ev_if.ev_valid_o); end
        send_sample(4'b0001, -1, -1);
        pop_one(v, i, p);
        void'(mq.pop_front());
        checks++;
        if (v !== 1'b1 || i !== 2'd0 || p !== 1'b1) begin
            errors++; $display("FAIL post_reset_cnt4: valid=%b idx=%0d press=%b want 1/0/1", v, i, p);
        end
    endtask

    task automatic test_glitch();
        logic [5:0] seq;
        logic v, p; logic [IW-1:0] i;
        seq = 6'b111011;
        for (int n = 0; n < 6; n++) begin
            send_sample({1'b0, seq[n], 2'b01}, -1, -1);
            checks++;
            if (ev_if.ev_valid_o !== (n == 5)) begin
                errors++; $display("FAIL glitch_valid[%0d]: valid=%b want %0b", n, ev_if.ev_valid_o, (n == 5));
            end
        end
        pop_one(v, i, p);
        void'(mq.pop_front());
        checks++;
        if (v !== 1'b1 || i !== 2'd2 || p !== 1'b1 || pressed !== 4'b0101) begin
            errors++; $display("FAIL glitch_press: v=%b idx=%0d press=%b pressed=%b want 1/2/1/0101", v, i, p, pressed);
        end
        repeat (4) send_sample(4'b0001, -1, -1);
        pop_one(v, i, p);
        void'(mq.pop_front());
        checks++;
        if (v !== 1'b1 || i !== 2'd2 || p !== 1'b0 || pressed !== 4'b0001) begin
            errors++; $display("FAIL glitch_release: v=%b idx=%0d press=%b pressed=%b want 1/2/0/0001", v, i, p, pressed);
        end
    endtask

    task automatic test_simultaneous();
        logic v, p; logic [IW-1:0] i;
        logic [N-1:0] exp;
        repeat (4) send_sample(4'b0000, -1, -1);
        pop_one(v, i, p);
        void'(mq.pop_front());
        repeat (3) send_sample(4'b1111, -1, -1);
        sampled = 4'b1111; but_oe = 1'b1;
        tick();
        but_oe = 1'b0;
        checks++;
        if (pressed !== 4'b0000 || busy !== 1'b1) begin
            errors++; $display("FAIL simul_first_cycle: pressed=%b busy=%b want 0000/1", pressed, busy);
        end
        for (int j = 0; j < N; j++) begin
            tick();
            exp = N'((1 << (j + 1)) - 1);
            checks++;
            if (pressed !== exp || ev_if.ev_valid_o !== 1'b1) begin
                errors++; $display("FAIL simul_cycle[%0d]: pressed=%b valid=%b want %b/1", j, pressed, ev_if.ev_valid_o, exp);
            end
        end
        model_step(4'b1111, -1, -1);
        checks++;
        if (busy !== 1'b0 || ev_if.ev_idx_o !== 2'd0 || ev_if.ev_press_o !== 1'b1) begin
            errors++; $display("FAIL simul_head: busy=%b idx=%0d press=%b want 0/0/1", busy, ev_if.ev_idx_o, ev_if.ev_press_o);
        end
    endtask

    task automatic test_overflow();
        logic v, p; logic [IW-1:0] i;
        repeat (3) send_sample(4'b0000, -1, -1);
        checks++;
        if (pressed !== 4'b1111 || overflow !== 1'b0) begin
            errors++; $display("FAIL ovf_pre: pressed=%b overflow=%b want 1111/0", pressed, overflow);
        end
        send_sample(4'b0000, -1, 3);
        checks++;
        if (pressed !== 4'b0000 || overflow !== 1'b1) begin
            errors++; $display("FAIL ovf_set: pressed=%b overflow=%b want 0000/1", pressed, overflow);
        end
        for (int k = 0; k < N; k++) begin
            pop_one(v, i, p);
            void'(mq.pop_front());
            checks++;
            if (v !== 1'b1 || i !== IW'(k) || p !== 1'b1) begin
                errors++; $display("FAIL ovf_drain[%0d]: v=%b idx=%0d press=%b want 1/%0d/1", k, v, i, p, k);
            end
        end
        checks++;
        if (ev_if.ev_valid_o !== 1'b0) begin errors++; $display("FAIL ovf_dropped: valid=%b want 0", ev_if.ev_valid_o); end
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        ovf_m   = 1'b0;
        checks++;
        if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: overflow=%b want 0", overflow); end
    endtask

    task automatic test_full_pushpop();
        logic v, p; logic [IW-1:0] i;
        ev_t e;
        repeat (4) send_sample(4'b1111, -1, -1);
        repeat (3) send_sample(4'b1110, -1, -1);
        send_sample(4'b1110, 0, -1);
        checks++;
        if (overflow !== 1'b0 || pressed !== 4'b1110) begin
            errors++; $display("FAIL full_pushpop: overflow=%b pressed=%b want 0/1110", overflow, pressed);
        end
        while (mq.size() > 0) begin
            e = mq.pop_front();
            pop_one(v, i, p);
            checks++;
            if (v !== 1'b1 || i !== IW'(e.idx) || p !== e.press) begin
                errors++; $display("FAIL full_drain: v=%b idx=%0d press=%b want 1/%0d/%0b", v, i, p, e.idx, e.press);
            end
        end
        checks++;
        if (ev_if.ev_valid_o !== 1'b0) begin errors++; $display("FAIL full_empty: valid=%b want 0", ev_if.ev_valid_o); end
    endtask

    task automatic test_pending();
        logic v, p; logic [IW-1:0] i;
        repeat (2) send_sample(4'b1111, -1, -1);
        sampled = 4'b1111; but_oe = 1'b1; tick();
        but_oe = 1'b0; tick();
        sampled = 4'b1111; but_oe = 1'b1; tick();
        but_oe = 1'b0; tick();
        sampled = 4'b1110; but_oe = 1'b1; tick();
        but_oe = 1'b0;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL pend_gap: busy=%b want 0", busy); end
        tick();
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL pend_rescan: busy=%b want 1", busy); end
        for (int t = 0; t < N; t++) tick();
        model_step(4'b1111, -1, -1);
        model_step(4'b1110, -1, -1);
        checks++;
        if (busy !== 1'b0 || pressed !== pr_m || ev_if.ev_valid_o !== 1'b0) begin
            errors++; $display("FAIL pend_result: busy=%b pressed=%b valid=%b want 0/%b/0", busy, pressed, ev_if.ev_valid_o, pr_m);
        end
        send_sample(4'b1111, -1, -1);
        checks++;
        if (ev_if.ev_valid_o !== 1'b0) begin errors++; $display("FAIL pend_cnt3: valid=%b want 0", ev_if.ev_valid_o); end
        send_sample(4'b1111, -1, -1);
        pop_one(v, i, p);
        void'(mq.pop_front());
        checks++;
        if (v !== 1'b1 || i !== 2'd0 || p !== 1'b1) begin
            errors++; $display("FAIL pend_cnt4: v=%b idx=%0d press=%b want 1/0/1", v, i, p);
        end
    endtask

    task automatic test_empty_pop();
        logic v, p; logic [IW-1:0] i;
        pop_one(v, i, p);
        pop_one(v, i, p);
        checks++;
        if (ev_if.ev_valid_o !== 1'b0) begin errors++; $display("FAIL empty_pop: valid=%b want 0", ev_if.ev_valid_o); end
        repeat (4) send_sample(4'b1110, -1, -1);
        checks++;
        if (ev_if.ev_valid_o !== 1'b1 || ev_if.ev_idx_o !== 2'd0 || ev_if.ev_press_o !== 1'b0) begin
            errors++; $display("FAIL empty_pop_head: valid=%b idx=%0d press=%b want 1/0/0",
                               ev_if.ev_valid_o, ev_if.ev_idx_o, ev_if.ev_press_o);
        end
        pop_one(v, i, p);
        void'(mq.pop_front());
        checks++;
        if (ev_if.ev_valid_o !== 1'b0) begin errors++; $display("FAIL empty_pop_after: valid=%b want 0", ev_if.ev_valid_o); end
    endtask

    task automatic test_random();
        logic [N-1:0] tgt, s;
        logic v, p; logic [IW-1:0] i;
        ev_t e;
        tgt = N'($urandom);
        for (int n = 0; n < 60; n++) begin
            for (int b = 0; b < N; b++) begin
                s[b] = ($urandom_range(0, 4) == 0) ? ~tgt[b] : tgt[b];
                if ($urandom_range(0, 9) == 0) tgt[b] = ~tgt[b];
            end
            send_sample(s, $urandom_range(0, 2*N-1), $urandom_range(0, 3*N-1));
            checks++;
            if (pressed !== pr_m || overflow !== ovf_m || ev_if.ev_valid_o !== (mq.size() > 0)) begin
                errors++; $display("FAIL rand_state[%0d]: pressed=%b ovf=%b valid=%b want %b/%b/%0b",
                                   n, pressed, overflow, ev_if.ev_valid_o, pr_m, ovf_m, (mq.size() > 0));
            end
            if ($urandom_range(0, 2) == 0) begin
                pop_one(v, i, p);
                checks++;
                if (mq.size() == 0) begin
                    if (v !== 1'b0) begin errors++; $display("FAIL rand_pop_empty[%0d]: valid=%b want 0", n, v); end
                end else begin
                    e = mq.pop_front();
                    if (v !== 1'b1 || i !== IW'(e.idx) || p !== e.press) begin
                        errors++; $display("FAIL rand_pop[%0d]: v=%b idx=%0d press=%b want 1/%0d/%0b", n, v, i, p, e.idx, e.press);
                    end
                end
            end
        end
        while (mq.size() > 0) begin
            e = mq.pop_front();
            pop_one(v, i, p);
            checks++;
            if (v !== 1'b1 || i !== IW'(e.idx) || p !== e.press) begin
                errors++; $display("FAIL rand_drain: v=%b idx=%0d press=%b want 1/%0d/%0b", v, i, p, e.idx, e.press);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_debounce();
        test_reset_midscan();
        test_glitch();
        test_simultaneous();
        test_overflow();
        test_full_pushpop();
        test_pending();
        test_empty_pop();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
